// File: rtl/trace_event_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_event_gen_if
// Brief    : Pipeline retire events in, trace beats and statistics out.
// Revision : 1.0 - initial release
// ============================================================================
interface trace_event_gen_if #(
    parameter int CNT_W = 32
);
    logic             ev_regwrite;
    logic [2:0]       ev_wreg;
    logic [15:0]      ev_wdata;
    logic             ev_memread;
    logic             ev_memwrite;
    logic [15:0]      ev_addr;
    logic [15:0]      ev_mdata_in;
    logic [15:0]      ev_mdata_out;
    logic             ev_halt;
    logic             dcache_hit;
    logic             icache_hit;
    logic             dcache_req;
    logic             icache_req;
    logic             tr_valid;
    logic             tr_ready;
    logic [1:0]       tr_type;
    logic [15:0]      tr_arg0;
    logic [15:0]      tr_arg1;
    logic [CNT_W-1:0] tr_cycle;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] inst_count;
    logic             overflow;
    logic             done;
    logic [CNT_W-1:0] dc_hits;
    logic [CNT_W-1:0] ic_hits;
    logic [CNT_W-1:0] dc_reqs;
    logic [CNT_W-1:0] ic_reqs;

    modport master (
        input  ev_regwrite, ev_wreg, ev_wdata, ev_memread, ev_memwrite, ev_addr,
               ev_mdata_in, ev_mdata_out, ev_halt,
               dcache_hit, icache_hit, dcache_req, icache_req, tr_ready,
        output tr_valid, tr_type, tr_arg0, tr_arg1, tr_cycle,
               cycle_count, inst_count, overflow, done,
               dc_hits, ic_hits, dc_reqs, ic_reqs
    );

    modport slave (
        output ev_regwrite, ev_wreg, ev_wdata, ev_memread, ev_memwrite, ev_addr,
               ev_mdata_in, ev_mdata_out, ev_halt,
               dcache_hit, icache_hit, dcache_req, icache_req, tr_ready,
        input  tr_valid, tr_type, tr_arg0, tr_arg1, tr_cycle,
               cycle_count, inst_count, overflow, done,
               dc_hits, ic_hits, dc_reqs, ic_reqs
    );
endinterface
`default_nettype wire

// File: rtl/trace_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : trace_event_gen
// Brief    : Commit-trace producer: timestamps retire events, buffers them per
//            cycle and serializes one event per valid/ready beat.
//            Optional cache statistics under macro TRACE_CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module trace_event_gen #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    trace_event_gen_if.master trc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [1:0] c_typeReg   = 2'd0;
    localparam logic [1:0] c_typeLoad  = 2'd1;
    localparam logic [1:0] c_typeStore = 2'd2;
    localparam logic [1:0] c_typeHalt  = 2'd3;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // flags bit order matches beat emission order: {halt, store, load, reg}
    typedef struct packed {
        logic [3:0]       flags;
        logic [2:0]       wreg;
        logic [15:0]      wdata;
        logic [15:0]      addr;
        logic [15:0]      stData;
        logic [15:0]      ldData;
        logic [15:0]      instLo;
        logic [CNT_W-1:0] cyc;
    } record_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cycleCount;
    logic [CNT_W-1:0] r_instCount;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    record_t          r_mem [FIFO_DEPTH];
    logic [3:0]       r_issued;
    logic             r_lastBeat;
    logic             r_overflow;
    logic             r_trValid;
    logic [1:0]       r_trType;
    logic [15:0]      r_trArg0;
    logic [15:0]      r_trArg1;
    logic [CNT_W-1:0] r_trCycle;

    logic             w_run;
    logic             w_active;
    logic             w_instEvent;
    record_t          w_newRec;
    logic [PW-1:0]    w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_hs;
    logic             w_pop;
    logic             w_slotFree;
    logic             w_push;
    logic             w_overwrite;
    logic             w_drop;
    logic [AW-1:0]    w_headIdx;
    logic [AW-1:0]    w_nextIdx;
    record_t          w_candRec;
    logic [3:0]       w_candRem;
    logic             w_candAvail;
    logic             w_load;
    logic [1:0]       w_beatType;
    logic [3:0]       w_beatBit;
    logic             w_beatLast;
    logic [15:0]      w_beatArg0;
    logic [15:0]      w_beatArg1;
    logic             w_done;

    assign w_run       = (r_state == S_RUN);
    assign w_instEvent = trc.ev_regwrite | trc.ev_memwrite | trc.ev_halt;
    assign w_active    = w_run & (w_instEvent | trc.ev_memread);

    // A simultaneous load and store is reported as the store only
    always_comb begin
        w_newRec        = '0;
        w_newRec.flags  = {trc.ev_halt, trc.ev_memwrite,
                           trc.ev_memread & ~trc.ev_memwrite, trc.ev_regwrite};
        w_newRec.wreg   = trc.ev_wreg;
        w_newRec.wdata  = trc.ev_wdata;
        w_newRec.addr   = trc.ev_addr;
        w_newRec.stData = trc.ev_mdata_in;
        w_newRec.ldData = trc.ev_mdata_out;
        w_newRec.instLo = r_instCount[15:0];
        w_newRec.cyc    = r_cycleCount;
    end

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_hs       = r_trValid & trc.tr_ready;
    assign w_pop      = w_hs & r_lastBeat;
    assign w_slotFree = ~r_trValid | trc.tr_ready;

    // A pop at the same edge frees the slot, so a push into a full FIFO still lands
    assign w_push      = w_active & (~w_full | w_pop);
    assign w_drop      = w_active & w_full & ~w_pop;
    assign w_overwrite = w_drop & trc.ev_halt;

    // The next beat comes from the following record when the head retires this edge
    assign w_headIdx   = r_rptr[AW-1:0];
    assign w_nextIdx   = r_rptr[AW-1:0] + AW'(1);
    assign w_candRec   = w_pop ? r_mem[w_nextIdx] : r_mem[w_headIdx];
    assign w_candRem   = w_pop ? w_candRec.flags : (w_candRec.flags & ~r_issued);
    assign w_candAvail = w_pop ? (w_count > PW'(1)) : (~w_empty && (w_candRem != 4'b0000));
    assign w_load      = w_slotFree & w_candAvail;

    always_comb begin
        w_beatType = c_typeReg;
        w_beatBit  = 4'b0001;
        if (w_candRem[0]) begin
            w_beatType = c_typeReg;
            w_beatBit  = 4'b0001;
        end else if (w_candRem[1]) begin
            w_beatType = c_typeLoad;
            w_beatBit  = 4'b0010;
        end else if (w_candRem[2]) begin
            w_beatType = c_typeStore;
            w_beatBit  = 4'b0100;
        end else if (w_candRem[3]) begin
            w_beatType = c_typeHalt;
            w_beatBit  = 4'b1000;
        end
    end

    assign w_beatLast = ((w_candRem & ~w_beatBit) == 4'b0000);

    always_comb begin
        w_beatArg0 = '0;
        w_beatArg1 = '0;
        case (w_beatType)
            c_typeReg: begin
                w_beatArg0 = {13'b0, w_candRec.wreg};
                w_beatArg1 = w_candRec.wdata;
            end
            c_typeLoad: begin
                w_beatArg0 = w_candRec.addr;
                w_beatArg1 = w_candRec.ldData;
            end
            c_typeStore: begin
                w_beatArg0 = w_candRec.addr;
                w_beatArg1 = w_candRec.stData;
            end
            default: begin
                w_beatArg0 = '0;
                w_beatArg1 = w_candRec.instLo;
            end
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (trc.ev_halt) begin
                    w_stateNext = S_HALTED;
                end
            end
            S_HALTED: begin
                if (w_hs && (r_trType == c_typeHalt)) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_stateNext = S_RUN;
            end
        endcase
    end

    // ------------------------------------------------------- FIFO storage
    // Halt on a full FIFO replaces the newest record so the HALT beat survives
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_newRec;
        end else if (w_overwrite) begin
            r_mem[r_wptr[AW-1:0] - AW'(1)] <= w_newRec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycleCount <= '0;
            r_instCount  <= '0;
        end else if (w_run) begin
            r_cycleCount <= r_cycleCount + CNT_W'(1);
            if (w_instEvent) begin
                r_instCount <= r_instCount + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------- beat serializer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trValid  <= 1'b0;
            r_trType   <= '0;
            r_trArg0   <= '0;
            r_trArg1   <= '0;
            r_trCycle  <= '0;
            r_issued   <= '0;
            r_lastBeat <= 1'b0;
        end else if (w_load) begin
            r_trValid  <= 1'b1;
            r_trType   <= w_beatType;
            r_trArg0   <= w_beatArg0;
            r_trArg1   <= w_beatArg1;
            r_trCycle  <= w_candRec.cyc;
            r_issued   <= (w_pop ? 4'b0000 : r_issued) | w_beatBit;
            r_lastBeat <= w_beatLast;
        end else begin
            if (w_slotFree) begin
                r_trValid <= 1'b0;
            end
            if (w_pop) begin
                r_issued <= '0;
            end
        end
    end

    assign trc.tr_valid    = r_trValid;
    assign trc.tr_type     = r_trType;
    assign trc.tr_arg0     = r_trArg0;
    assign trc.tr_arg1     = r_trArg1;
    assign trc.tr_cycle    = r_trCycle;
    assign trc.cycle_count = r_cycleCount;
    assign trc.inst_count  = r_instCount;
    assign trc.overflow    = r_overflow;
    assign trc.done        = w_done;

    // ------------------------------------------------------ cache statistics
`ifdef TRACE_CACHE_STATS_EN
    logic [CNT_W-1:0] r_dcHits;
    logic [CNT_W-1:0] r_icHits;
    logic [CNT_W-1:0] r_dcReqs;
    logic [CNT_W-1:0] r_icReqs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcHits <= '0;
            r_icHits <= '0;
            r_dcReqs <= '0;
            r_icReqs <= '0;
        end else if (w_run) begin
            if (trc.dcache_hit) r_dcHits <= r_dcHits + CNT_W'(1);
            if (trc.icache_hit) r_icHits <= r_icHits + CNT_W'(1);
            if (trc.dcache_req) r_dcReqs <= r_dcReqs + CNT_W'(1);
            if (trc.icache_req) r_icReqs <= r_icReqs + CNT_W'(1);
        end
    end

    assign trc.dc_hits = r_dcHits;
    assign trc.ic_hits = r_icHits;
    assign trc.dc_reqs = r_dcReqs;
    assign trc.ic_reqs = r_icReqs;
`else
    logic w_unusedCacheIns;

    assign w_unusedCacheIns = ^{trc.dcache_hit, trc.icache_hit, trc.dcache_req, trc.icache_req};
    assign trc.dc_hits = '0;
    assign trc.ic_hits = '0;
    assign trc.dc_reqs = '0;
    assign trc.ic_reqs = '0;
`endif

endmodule
`default_nettype wire
